// File: rtl/mcu51_bus_pkg.sv
// Shared types and constants for the 8051-style external bus interface.
// Holds the state encoding and the strobe-decode helpers used by the bus FSM.
package mcu51_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_WAIT_STB = 3'd2,
        ST_CODE_RD  = 3'd3,
        ST_X_RD     = 3'd4,
        ST_X_WR     = 3'd5,
        ST_WR_HOLD  = 3'd6
    } bus_state_e;

    localparam logic [7:0] P0_RST_DEF = 8'hFF;
    localparam int         TO_W       = 4;

    // low = {psen_low, rd_low, wr_low}; callers reject multiple-low first
    function automatic bus_state_e strobe_state(input logic [2:0] low);
        bus_state_e s;
        if (low[2])      s = ST_CODE_RD;
        else if (low[1]) s = ST_X_RD;
        else if (low[0]) s = ST_X_WR;
        else             s = ST_WAIT_STB;
        return s;
    endfunction

    function automatic logic multi_low(input logic [2:0] low);
        return (low & (low - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/bus_wdog.sv
// Saturating transaction watchdog: cleared while the bus is idle, counts otherwise.
// hit fires on the clock whose increment would reach TIMEOUT_CLKS.
module bus_wdog
    import mcu51_bus_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [TO_W-1:0] HIT_VAL = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    assign hit = en && !clr && (cnt_q == HIT_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ext_bus_if.sv
// 8051-style multiplexed external bus driver: turns control-unit strobes into
// P0/P2 pad activity, emulates the address latch and returns captured bytes.
//
// state    | meaning
// IDLE     | bus released, P2 holds last address high byte
// ADDR     | ALE high, address driven on P0/P2 and tracked by a_lat
// WAIT_STB | ALE fell, no strobe yet, address held on P0
// CODE_RD  | PSEN low, sampling P0_in
// X_RD     | RD low, sampling P0_in
// X_WR     | WR low, driving wdata on P0
// WR_HOLD  | one clock of write-data hold after WR rises
module ext_bus_if
    import mcu51_bus_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 15,
    parameter logic [7:0] P0_RST       = P0_RST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ALE,
    input  logic        PSEN,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] addr,
    input  logic        use_ri,
    input  logic [7:0]  P2_sfr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  P0_in,
    output logic [7:0]  P0_out,
    output logic        P0_oe,
    output logic [7:0]  P2_out,
    output logic [7:0]  a_lat,
    output logic [7:0]  code_byte,
    output logic        code_valid,
    output logic [7:0]  xdata_byte,
    output logic        xdata_valid,
    output logic        wr_done,
    output logic        bus_err
);

    bus_state_e state_q, state_d;
    logic [7:0] p0_out_q, p0_out_d;
    logic       p0_oe_q, p0_oe_d;
    logic [7:0] p2_out_q, p2_out_d;
    logic [7:0] a_lat_q, a_lat_d;
    logic [7:0] sample_q, sample_d;
    logic [7:0] code_byte_q, code_byte_d;
    logic [7:0] xdata_byte_q, xdata_byte_d;
    logic       code_valid_q, code_valid_d;
    logic       xdata_valid_q, xdata_valid_d;
    logic       wr_done_q, wr_done_d;
    logic       bus_err_q, bus_err_d;

    logic [2:0] low;
    logic       any_low;
    logic       multi;
    logic       wd_hit;

    assign low     = {~PSEN, ~RD, ~WR};
    assign any_low = |low;
    assign multi   = multi_low(low);

    bus_wdog #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_wdog (
        .clk  (clk),
        .rst_n(reset),
        .clr  (state_q == ST_IDLE),
        .en   (state_q != ST_IDLE),
        .hit  (wd_hit)
    );

    always_comb begin
        state_d       = state_q;
        bus_err_d     = 1'b0;
        code_valid_d  = 1'b0;
        xdata_valid_d = 1'b0;
        wr_done_d     = 1'b0;
        code_byte_d   = code_byte_q;
        xdata_byte_d  = xdata_byte_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ALE) begin
                    if (any_low) bus_err_d = 1'b1;
                    else         state_d   = ST_ADDR;
                end else if (multi) begin
                    bus_err_d = 1'b1;
                end else if (any_low) begin
                    // ALE suppressed: reuse whatever the latch already holds
                    state_d = strobe_state(low);
                end
            end
            ST_ADDR, ST_WAIT_STB: begin
                if (ALE) begin
                    if (any_low) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else if (multi) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = strobe_state(low);
                end
            end
            ST_CODE_RD: begin
                if (!PSEN) begin
                    if (ALE || !RD || !WR) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    code_valid_d = 1'b1;
                    code_byte_d  = sample_q;
                    state_d      = ALE ? ST_ADDR : ST_IDLE;
                end
            end
            ST_X_RD: begin
                if (!RD) begin
                    if (ALE || !PSEN || !WR) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    xdata_valid_d = 1'b1;
                    xdata_byte_d  = sample_q;
                    state_d       = ALE ? ST_ADDR : ST_IDLE;
                end
            end
            ST_X_WR: begin
                if (!WR) begin
                    if (ALE || !PSEN || !RD) begin
                        bus_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    wr_done_d = 1'b1;
                    state_d   = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: state_d = ALE ? ST_ADDR : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Watchdog abort wins over any completion in the same clock
        if (wd_hit) begin
            state_d       = ST_IDLE;
            bus_err_d     = 1'b1;
            code_valid_d  = 1'b0;
            xdata_valid_d = 1'b0;
            wr_done_d     = 1'b0;
            code_byte_d   = code_byte_q;
            xdata_byte_d  = xdata_byte_q;
        end
    end

    // Pad outputs are registered from the next state so they change with it
    always_comb begin
        p0_out_d = P0_RST;
        p0_oe_d  = 1'b0;
        p2_out_d = p2_out_q;
        a_lat_d  = a_lat_q;
        sample_d = sample_q;

        unique case (state_d)
            ST_ADDR: begin
                p0_out_d = addr[7:0];
                p0_oe_d  = 1'b1;
                p2_out_d = use_ri ? P2_sfr : addr[15:8];
                a_lat_d  = addr[7:0];
            end
            ST_WAIT_STB: begin
                p0_out_d = p0_out_q;
                p0_oe_d  = 1'b1;
            end
            ST_CODE_RD, ST_X_RD: sample_d = P0_in;
            ST_X_WR: begin
                p0_out_d = wdata;
                p0_oe_d  = 1'b1;
            end
            ST_WR_HOLD: begin
                p0_out_d = p0_out_q;
                p0_oe_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            p0_out_q      <= P0_RST;
            p0_oe_q       <= 1'b0;
            p2_out_q      <= P0_RST;
            a_lat_q       <= 8'h00;
            sample_q      <= 8'h00;
            code_byte_q   <= 8'h00;
            xdata_byte_q  <= 8'h00;
            code_valid_q  <= 1'b0;
            xdata_valid_q <= 1'b0;
            wr_done_q     <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            p0_out_q      <= p0_out_d;
            p0_oe_q       <= p0_oe_d;
            p2_out_q      <= p2_out_d;
            a_lat_q       <= a_lat_d;
            sample_q      <= sample_d;
            code_byte_q   <= code_byte_d;
            xdata_byte_q  <= xdata_byte_d;
            code_valid_q  <= code_valid_d;
            xdata_valid_q <= xdata_valid_d;
            wr_done_q     <= wr_done_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign P0_out      = p0_out_q;
    assign P0_oe       = p0_oe_q;
    assign P2_out      = p2_out_q;
    assign a_lat       = a_lat_q;
    assign code_byte   = code_byte_q;
    assign code_valid  = code_valid_q;
    assign xdata_byte  = xdata_byte_q;
    assign xdata_valid = xdata_valid_q;
    assign wr_done     = wr_done_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_ext_bus_if.sv
// Directed bench for ext_bus_if: per-clock vector table plus hand-written
// sequences for back-to-back fetch, watchdog timeout and async reset.
module tb_ext_bus_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        ALE, PSEN, RD, WR, use_ri;
    logic [15:0] addr;
    logic [7:0]  P2_sfr, wdata, P0_in;
    logic [7:0]  P0_out, P2_out, a_lat, code_byte, xdata_byte;
    logic        P0_oe, code_valid, xdata_valid, wr_done, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_bus_if dut (
        .clk(clk), .reset(reset), .ALE(ALE), .PSEN(PSEN), .RD(RD), .WR(WR),
        .addr(addr), .use_ri(use_ri), .P2_sfr(P2_sfr), .wdata(wdata), .P0_in(P0_in),
        .P0_out(P0_out), .P0_oe(P0_oe), .P2_out(P2_out), .a_lat(a_lat),
        .code_byte(code_byte), .code_valid(code_valid),
        .xdata_byte(xdata_byte), .xdata_valid(xdata_valid),
        .wr_done(wr_done), .bus_err(bus_err)
    );

    typedef struct {
        logic        ale, psen, rd, wr;
        logic [15:0] addr;
        logic        use_ri;
        logic [7:0]  p2_sfr, wdata, p0_in;
        logic [44:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [44:0] pack(input logic [7:0] p0, input logic oe,
                                         input logic [7:0] p2, input logic [7:0] al,
                                         input logic [7:0] cb, input logic cv,
                                         input logic [7:0] xb, input logic xv,
                                         input logic wd, input logic er);
        return {p0, oe, p2, al, cb, cv, xb, xv, wd, er};
    endfunction

    function automatic logic [44:0] outs();
        return {P0_out, P0_oe, P2_out, a_lat, code_byte, code_valid,
                xdata_byte, xdata_valid, wr_done, bus_err};
    endfunction

    task automatic row(input logic ale, input logic psen, input logic rd, input logic wr,
                       input logic [15:0] ad, input logic ri, input logic [7:0] p2s,
                       input logic [7:0] wd, input logic [7:0] pin,
                       input logic [7:0] e_p0, input logic e_oe, input logic [7:0] e_p2,
                       input logic [7:0] e_al, input logic [7:0] e_cb, input logic e_cv,
                       input logic [7:0] e_xb, input logic e_xv, input logic e_wd,
                       input logic e_er);
        vec_t v;
        v.ale = ale; v.psen = psen; v.rd = rd; v.wr = wr;
        v.addr = ad; v.use_ri = ri; v.p2_sfr = p2s; v.wdata = wd; v.p0_in = pin;
        v.exp = pack(e_p0, e_oe, e_p2, e_al, e_cb, e_cv, e_xb, e_xv, e_wd, e_er);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ALE = 1'b0; PSEN = 1'b1; RD = 1'b1; WR = 1'b1;
        addr = 16'h0000; use_ri = 1'b0; P2_sfr = 8'h00; wdata = 8'h00; P0_in = 8'h00;
    endtask

    initial begin : main
        int n;
        logic seen;

        idle_in();
        reset = 1'b0;

        // code fetch 12A5 / 74
        row(1,1,1,1,16'h12A5,0,8'h00,8'h00,8'h00, 8'hA5,1,8'h12,8'hA5,8'h00,0,8'h00,0,0,0);
        row(1,1,1,1,16'h12A5,0,8'h00,8'h00,8'h00, 8'hA5,1,8'h12,8'hA5,8'h00,0,8'h00,0,0,0);
        for (int i = 0; i < 3; i++)
            row(0,0,1,1,16'h12A5,0,8'h00,8'h00,8'h74, 8'hFF,0,8'h12,8'hA5,8'h00,0,8'h00,0,0,0);
        row(0,1,1,1,16'h12A5,0,8'h00,8'h00,8'h74, 8'hFF,0,8'h12,8'hA5,8'h74,1,8'h00,0,0,0);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h12,8'hA5,8'h74,0,8'h00,0,0,0);
        // MOVX write @DPTR 8001 / 3C
        row(1,1,1,1,16'h8001,0,8'h00,8'h3C,8'h00, 8'h01,1,8'h80,8'h01,8'h74,0,8'h00,0,0,0);
        for (int i = 0; i < 4; i++)
            row(0,1,1,0,16'h8001,0,8'h00,8'h3C,8'h00, 8'h3C,1,8'h80,8'h01,8'h74,0,8'h00,0,0,0);
        row(0,1,1,1,16'h8001,0,8'h00,8'h3C,8'h00, 8'h3C,1,8'h80,8'h01,8'h74,0,8'h00,0,1,0);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h80,8'h01,8'h74,0,8'h00,0,0,0);
        // MOVX read @Ri, P2 from SFR
        row(1,1,1,1,16'h0010,1,8'h55,8'h00,8'h00, 8'h10,1,8'h55,8'h10,8'h74,0,8'h00,0,0,0);
        for (int i = 0; i < 2; i++)
            row(0,1,0,1,16'h0010,1,8'h55,8'h00,8'h9E, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h00,0,0,0);
        row(0,1,1,1,16'h0010,1,8'h55,8'h00,8'h9E, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h9E,1,0,0);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h9E,0,0,0);
        // conflicts from IDLE
        row(0,0,0,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h9E,0,0,1);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h9E,0,0,0);
        row(1,0,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h9E,0,0,1);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h9E,0,0,0);
        // ALE-less read reusing latch
        row(0,1,0,1,16'h0000,0,8'h00,8'h00,8'h3A, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h9E,0,0,0);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h3A, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h3A,1,0,0);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h55,8'h10,8'h74,0,8'h3A,0,0,0);
        // two strobes on ALE fall
        row(1,1,1,1,16'h4321,0,8'h00,8'h00,8'h00, 8'h21,1,8'h43,8'h21,8'h74,0,8'h3A,0,0,0);
        row(0,0,1,0,16'h4321,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h43,8'h21,8'h74,0,8'h3A,0,0,1);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h43,8'h21,8'h74,0,8'h3A,0,0,0);
        // WAIT_STB then address restart, then write
        row(1,1,1,1,16'h7788,0,8'h00,8'h00,8'h00, 8'h88,1,8'h77,8'h88,8'h74,0,8'h3A,0,0,0);
        row(0,1,1,1,16'h7788,0,8'h00,8'h00,8'h00, 8'h88,1,8'h77,8'h88,8'h74,0,8'h3A,0,0,0);
        row(1,1,1,1,16'h7799,0,8'h00,8'h00,8'h00, 8'h99,1,8'h77,8'h99,8'h74,0,8'h3A,0,0,0);
        row(0,1,1,0,16'h7799,0,8'h00,8'h5A,8'h00, 8'h5A,1,8'h77,8'h99,8'h74,0,8'h3A,0,0,0);
        row(0,1,1,1,16'h7799,0,8'h00,8'h5A,8'h00, 8'h5A,1,8'h77,8'h99,8'h74,0,8'h3A,0,1,0);
        row(0,1,1,1,16'h0000,0,8'h00,8'h00,8'h00, 8'hFF,0,8'h77,8'h99,8'h74,0,8'h3A,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(outs()),
            64'(pack(8'hFF,0,8'hFF,8'h00,8'h00,0,8'h00,0,0,0)));
        reset = 1'b1;
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            ALE = vq[i].ale; PSEN = vq[i].psen; RD = vq[i].rd; WR = vq[i].wr;
            addr = vq[i].addr; use_ri = vq[i].use_ri; P2_sfr = vq[i].p2_sfr;
            wdata = vq[i].wdata; P0_in = vq[i].p0_in;
            tick();
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(vq[i].exp));
        end

        // back-to-back: PSEN rise with ALE high goes straight to ADDR
        idle_in(); ALE = 1'b1; addr = 16'h2233; tick();
        ALE = 1'b0; PSEN = 1'b0; P0_in = 8'hC5; tick();
        PSEN = 1'b1; ALE = 1'b1; addr = 16'h2240; tick();
        chk("b2b_rise", 64'({code_valid, code_byte, P0_oe, P0_out, a_lat, bus_err}),
            64'({1'b1, 8'hC5, 1'b1, 8'h40, 8'h40, 1'b0}));
        ALE = 1'b0; PSEN = 1'b0; P0_in = 8'h11; tick();
        chk("b2b_second_rd", 64'({code_valid, P0_oe}), 64'({1'b0, 1'b0}));
        PSEN = 1'b1; tick();
        chk("b2b_second_done", 64'({code_valid, code_byte}), 64'({1'b1, 8'h11}));
        idle_in(); tick();

        // timeout: ALE pulse, no strobe
        ALE = 1'b1; addr = 16'h00AA; tick();
        ALE = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 40) begin
            tick();
            n++;
            if (code_valid || xdata_valid || wr_done) seen = 1'b1;
            if (bus_err) break;
        end
        chk("timeout_latency", 64'(n), 64'(15));
        chk("timeout_release", 64'({P0_oe, P0_out, seen}), 64'({1'b0, 8'hFF, 1'b0}));
        tick();
        chk("timeout_pulse_end", 64'(bus_err), 64'(0));

        // async reset in the middle of a write
        ALE = 1'b1; addr = 16'h8001; wdata = 8'h3C; tick();
        ALE = 1'b0; WR = 1'b0; tick(); tick();
        chk("wr_before_reset", 64'({P0_oe, P0_out}), 64'({1'b1, 8'h3C}));
        #2 reset = 1'b0;
        #1;
        chk("async_reset", 64'(outs()),
            64'(pack(8'hFF,0,8'hFF,8'h00,8'h00,0,8'h00,0,0,0)));
        WR = 1'b1;
        #2 reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_done || bus_err || P0_oe) seen = 1'b1;
        end
        chk("no_wr_done_after_reset", 64'(seen), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
